// File: rtl/banked_data_memory_pkg.sv
// Shared types, defaults and helpers for the banked data memory.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: default widths/depth, FSM state encoding, index-width helper.
package banked_data_memory_pkg;

  // Defaults match the gen-1 8x256 array this block replaces.
  localparam int DMEM_DW    = 8;
  localparam int DMEM_AW    = 8;
  localparam int DMEM_DEPTH = 256;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } dmem_state_e;

  // Word-index width for a DEPTH-entry array; never below 1 so a
  // single-word memory still gets a legal vector.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/banked_data_memory_if.sv
// CPU-side request/response bundle of the banked data memory.
// Latency: n/a (wiring only).
// Backpressure: master holds a request only while the slave drives ready.
// Ports (master view): out req, writeEn (0=write), address, byteEn, write_data;
//                      in  ready, read_data, read_valid, err, busy.
interface banked_data_memory_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) ();

  logic                      req;
  logic                      ready;
  logic                      writeEn;
  logic [ADDR_WIDTH-1:0]     address;
  logic [DATA_WIDTH/8-1:0]   byteEn;
  logic [DATA_WIDTH-1:0]     write_data;
  logic [DATA_WIDTH-1:0]     read_data;
  logic                      read_valid;
  logic                      err;
  logic                      busy;

  modport master (
    output req, writeEn, address, byteEn, write_data,
    input  ready, read_data, read_valid, err, busy
  );

  modport slave (
    input  req, writeEn, address, byteEn, write_data,
    output ready, read_data, read_valid, err, busy
  );

endinterface

// File: rtl/banked_data_memory_dmem_array.sv
// DEPTH x DATA_WIDTH storage with byte-masked synchronous write, async read.
// Latency: write lands at the clock edge; read is combinational.
// Backpressure: none, one write port and one read port every cycle.
// Ports: clk; we, waddr, wbe, wdata (write side); raddr -> rdata (read side).
module dmem_array
  import banked_data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = DMEM_DW,
  parameter int DEPTH      = DMEM_DEPTH,
  parameter int IW         = idx_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [IW-1:0]           waddr,
  input  logic [DATA_WIDTH/8-1:0] wbe,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [IW-1:0]           raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately not reset; the wrapper's clear sweep
  // provides a known state when that is wanted.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (wbe[i]) begin
          mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/banked_data_memory.sv
// Single-port data memory for the dCPU load/store path with post-reset clear.
// Latency: reads return 1 cycle after accept; throughput 1 op per cycle.
// Backpressure: ready=0 during the clear sweep; req while not ready is dropped.
// Ports: clk, rst_n (async, active-low), bus (slave: req/ready, writeEn(0=wr),
//        address, byteEn, write_data, read_data, read_valid, err, busy).
module banked_data_memory
  import banked_data_memory_pkg::*;
#(
  parameter int DATA_WIDTH   = DMEM_DW,
  parameter int ADDR_WIDTH   = DMEM_AW,
  parameter int DEPTH        = DMEM_DEPTH,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  banked_data_memory_if.slave   bus
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = idx_width(DEPTH);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IW-1:0]       LAST_IDX  = IW'(DEPTH - 1);
  localparam dmem_state_e         RST_STATE = CLEAR_ON_RST ? ST_CLEAR : ST_RUN;

  dmem_state_e           state;
  logic [IW-1:0]         clr_cnt;
  logic                  ready_q;
  logic                  busy_q;
  logic                  rv_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rd_q;

  logic                  accept;
  logic                  in_range;
  logic [IW-1:0]         acc_idx;
  logic                  clearing;

  logic                  arr_we;
  logic [IW-1:0]         arr_waddr;
  logic [NB-1:0]         arr_wbe;
  logic [DATA_WIDTH-1:0] arr_wdata;
  logic [DATA_WIDTH-1:0] arr_rdata;

  assign accept   = bus.req & ready_q;
  assign in_range = ({1'b0, bus.address} < DEPTH_LIM);
  // Out-of-range addresses are parked on index 0 so the array is never
  // indexed past its end; their result is discarded anyway.
  assign acc_idx  = in_range ? bus.address[IW-1:0] : '0;
  assign clearing = (state == ST_CLEAR);

  // The sweep owns the write port while clearing; ready is low then, so
  // no accepted request can compete for it.
  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = acc_idx;
    arr_wbe   = bus.byteEn;
    arr_wdata = bus.write_data;
    if (clearing) begin
      arr_we    = 1'b1;
      arr_waddr = clr_cnt;
      arr_wbe   = '1;
      arr_wdata = '0;
    end else if (accept && !bus.writeEn && in_range) begin
      arr_we    = 1'b1;
    end
  end

  dmem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IW         (IW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wbe   (arr_wbe),
    .wdata (arr_wdata),
    .raddr (acc_idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RST_STATE;
      clr_cnt <= '0;
      ready_q <= 1'b0;
      busy_q  <= CLEAR_ON_RST;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      rv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_CLEAR: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          clr_cnt <= clr_cnt + 1'b1;
          // Raise ready on the same edge that writes the last word so the
          // sweep occupies exactly DEPTH cycles.
          if (clr_cnt == LAST_IDX) begin
            state   <= ST_RUN;
            clr_cnt <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept) begin
            err_q <= ~in_range;
            // read_data only moves on an accepted read and otherwise holds.
            if (bus.writeEn) begin
              rv_q <= 1'b1;
              rd_q <= in_range ? arr_rdata : '0;
            end
          end
        end
        default: begin
          state <= RST_STATE;
        end
      endcase
    end
  end

  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.read_valid = rv_q;
  assign bus.err        = err_q;
  assign bus.read_data  = rd_q;

endmodule

// File: tb/tb_banked_data_memory.sv
// Bench for banked_data_memory: two instances (32b x 256, 8b x 200),
// randomized + directed ops, reference model and response scoreboard.
module tb_banked_data_memory;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sweep_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Cycles since reset release; the block should be ready once DEPTH have passed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sweep_cnt <= 0;
    else if (sweep_cnt < 100000) sweep_cnt <= sweep_cnt + 1;
  end

  banked_data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus_a ();
  banked_data_memory_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) bus_b ();

  banked_data_memory #(
    .DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(256), .CLEAR_ON_RST(1'b1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );

  banked_data_memory #(
    .DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(200), .CLEAR_ON_RST(1'b1)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct {
    int          due;
    bit          rv;
    bit          er;
    logic [31:0] d;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rd [2];

  function automatic int depth_of(input int id);
    return (id == 0) ? 256 : 200;
  endfunction

  function automatic logic [31:0] dw_mask(input int id);
    return (id == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic bit model_ready(input int id);
    return sweep_cnt >= depth_of(id);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // After any reset the sweep zeroes every word before a request can land,
  // and anything in flight is lost.
  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      for (int w = 0; w < 256; w++) ref_mem[id][w] = '0;
      last_rd[id] = '0;
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic set_bus(input int id, input bit r, input bit we_n, input logic [7:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    if (id == 0) begin
      bus_a.req = r; bus_a.writeEn = we_n; bus_a.address = a;
      bus_a.byteEn = be; bus_a.write_data = wd;
    end else begin
      bus_b.req = r; bus_b.writeEn = we_n; bus_b.address = a;
      bus_b.byteEn = be[0]; bus_b.write_data = wd[7:0];
    end
  endtask

  // One request cycle; called #1 after a rising edge, returns #1 after the next.
  task automatic op(input int id, input bit we_n, input logic [7:0] a,
                    input logic [3:0] be, input logic [31:0] wd);
    exp_t e;
    bit   inr;
    set_bus(id, 1'b1, we_n, a, be, wd);
    if (model_ready(id)) begin
      inr  = int'(a) < depth_of(id);
      e.due = cyc + 1;
      e.rv  = we_n;
      e.er  = !inr;
      e.d   = (we_n && inr) ? ref_mem[id][a] : 32'h0;
      if (!we_n && inr) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) ref_mem[id][a][8*i +: 8] = wd[8*i +: 8];
        ref_mem[id][a] = ref_mem[id][a] & dw_mask(id);
      end
      if (we_n || !inr) begin
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    set_bus(id, 1'b0, 1'b1, 8'h00, 4'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset(input int hold);
    rst_n = 1'b0;
    model_reset();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!(model_ready(0) && model_ready(1)) && guard < 1000) begin
      idle(1);
      guard++;
    end
  endtask

  task automatic mon(input int id, input logic rdy, input logic bsy, input logic rv,
                     input logic er, input logic [31:0] rd);
    exp_t  e;
    bit    have;
    string t;
    t = (id == 0) ? "A" : "B";
    if (!rst_n) begin
      chk({t, ".rst_ready"}, {31'b0, rdy}, 32'd0);
      chk({t, ".rst_busy"},  {31'b0, bsy}, 32'd1);
      chk({t, ".rst_read_valid"}, {31'b0, rv}, 32'd0);
      chk({t, ".rst_err"},   {31'b0, er}, 32'd0);
      chk({t, ".rst_read_data"}, rd, 32'd0);
      return;
    end
    chk({t, ".ready"}, {31'b0, rdy}, {31'b0, model_ready(id)});
    chk({t, ".busy"},  {31'b0, bsy}, {31'b0, !model_ready(id)});
    have = (id == 0) ? (q_a.size() > 0) : (q_b.size() > 0);
    if (have) e = (id == 0) ? q_a[0] : q_b[0];
    if (rv || er) begin
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL %s.spurious: got read_valid=%b err=%b expected no response (cycle %0d)",
                 t, rv, er, cyc);
      end else begin
        if (id == 0) void'(q_a.pop_front());
        else         void'(q_b.pop_front());
        chk({t, ".resp_cycle"}, cyc, e.due);
        chk({t, ".read_valid"}, {31'b0, rv}, {31'b0, e.rv});
        chk({t, ".err"}, {31'b0, er}, {31'b0, e.er});
        if (e.rv) begin
          chk({t, ".read_data"}, rd, e.d);
          last_rd[id] = e.d;
        end
      end
    end else if (have && e.due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL %s.missing: got no response expected one due cycle %0d (cycle %0d)",
               t, e.due, cyc);
      if (id == 0) void'(q_a.pop_front());
      else         void'(q_b.pop_front());
    end
    if (!rv) chk({t, ".read_data_hold"}, rd, last_rd[id]);
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.ready, bus_a.busy, bus_a.read_valid, bus_a.err, bus_a.read_data);
    mon(1, bus_b.ready, bus_b.busy, bus_b.read_valid, bus_b.err, {24'b0, bus_b.read_data});
  end

  initial begin
    set_bus(0, 1'b0, 1'b1, 8'h00, 4'h0, 32'h0);
    set_bus(1, 1'b0, 1'b1, 8'h00, 4'h0, 32'h0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Writes during the sweep must be ignored.
    idle(10);
    op(0, 1'b0, 8'h05, 4'hF, 32'hFFFF_FFFF);
    op(1, 1'b0, 8'h05, 4'h1, 32'h0000_00FF);
    wait_ready();

    // Cleared contents, including both ends of the array.
    op(0, 1'b1, 8'h00, 4'h0, 32'h0);
    op(0, 1'b1, 8'hFF, 4'h0, 32'h0);
    op(0, 1'b1, 8'h05, 4'h0, 32'h0);
    op(1, 1'b1, 8'h05, 4'h0, 32'h0);

    // Byte-masked merge.
    op(0, 1'b0, 8'h10, 4'hF, 32'hDEAD_BEEF);
    op(0, 1'b0, 8'h10, 4'h1, 32'h0000_00AA);
    op(0, 1'b1, 8'h10, 4'h0, 32'h0);
    op(0, 1'b0, 8'h10, 4'h0, 32'h1234_5678);
    op(0, 1'b1, 8'h10, 4'h0, 32'h0);

    // Write then immediate read, then a burst of back-to-back reads.
    op(0, 1'b0, 8'h03, 4'hF, 32'h0000_005A);
    op(0, 1'b1, 8'h03, 4'h0, 32'h0);
    for (int i = 0; i < 8; i++) op(0, 1'b1, 8'(i), 4'h0, 32'h0);

    // Non-power-of-two depth: last legal word and out-of-range accesses.
    op(1, 1'b0, 8'hC8, 4'h1, 32'h77);
    op(1, 1'b1, 8'hC8, 4'h0, 32'h0);
    op(1, 1'b0, 8'hC7, 4'h1, 32'h33);
    op(1, 1'b1, 8'hC7, 4'h0, 32'h0);
    op(1, 1'b1, 8'hFF, 4'h0, 32'h0);
    op(1, 1'b1, 8'h00, 4'h0, 32'h0);

    for (int n = 0; n < 400; n++) begin
      int          id;
      bit          we_n;
      logic [7:0]  a;
      logic [3:0]  be;
      id   = int'($urandom_range(0, 1));
      we_n = 1'($urandom_range(0, 1));
      a    = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      be   = 4'($urandom_range(0, 15));
      op(id, we_n, a, be, $urandom);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(2);

    // Reset right after a read is accepted: its result must never appear.
    op(0, 1'b1, 8'h10, 4'h0, 32'h0);
    apply_reset(2);

    // Reset again partway through the sweep; it must restart from scratch.
    for (int i = 0; i < 100; i++) op(0, 1'b1, 8'h03, 4'h0, 32'h0);
    apply_reset(2);
    wait_ready();
    op(0, 1'b1, 8'h10, 4'h0, 32'h0);
    op(0, 1'b1, 8'h03, 4'h0, 32'h0);
    op(1, 1'b1, 8'hC7, 4'h0, 32'h0);
    idle(4);

    checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d responses outstanding expected 0/0", q_a.size(), q_b.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
